// File: rtl/memtest_pkg.sv
// Shared types and limits for the walking-ones memory test sequencer.
package memtest_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} t_WALK_STATE;
  localparam logic [7:0] c_ERR_MAX = 8'd255;
endpackage

// File: rtl/adder.sv
// Unsigned adder with carry-out; the carry flags a step past the top of the address space.
module adder #(
  parameter int p_WIDTH = 8
) (
  input  logic [p_WIDTH-1:0] i_A,
  input  logic [p_WIDTH-1:0] i_B,
  output logic [p_WIDTH-1:0] o_SUM,
  output logic               o_OVERFLOW
);
  assign {o_OVERFLOW, o_SUM} = {1'b0, i_A} + {1'b0, i_B};
endmodule

// File: rtl/mem_walk_ctrl.sv
// Walking-ones sequencer: writes a rotating one-hot pattern across a window,
// then reads it back and compares, reporting pass, error count and first failing address.
module mem_walk_ctrl
  import memtest_pkg::*;
#(
  parameter int p_ADDR_WIDTH = 8,
  parameter int p_DATA_WIDTH = 8,
  parameter int p_STRIDE     = 1
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_START,
  input  logic [p_ADDR_WIDTH-1:0] i_BASE_ADDR,
  input  logic [p_ADDR_WIDTH-1:0] i_LAST_ADDR,
  output logic                    o_BUSY,
  output logic                    o_DONE,
  output logic                    o_PASS,
  output logic [7:0]              o_ERR_COUNT,
  output logic [p_ADDR_WIDTH-1:0] o_FAIL_ADDR,
  output logic                    o_MEM_REQ,
  output logic                    o_MEM_WE,
  output logic [p_ADDR_WIDTH-1:0] o_MEM_ADDR,
  output logic [p_DATA_WIDTH-1:0] o_MEM_WDATA,
  input  logic                    i_MEM_ACK,
  input  logic [p_DATA_WIDTH-1:0] i_MEM_RDATA
);
  localparam logic [p_ADDR_WIDTH-1:0] c_STRIDE = p_ADDR_WIDTH'(p_STRIDE);
  localparam logic [p_DATA_WIDTH-1:0] c_PAT0   = p_DATA_WIDTH'(1);

  t_WALK_STATE             state;
  logic [p_ADDR_WIDTH-1:0] base_q, last_q;
  logic [p_DATA_WIDTH-1:0] pat;
  logic [p_ADDR_WIDTH-1:0] next_addr;
  logic                    next_ovf;

  adder #(.p_WIDTH(p_ADDR_WIDTH)) u_addr_inc (
    .i_A        (o_MEM_ADDR),
    .i_B        (c_STRIDE),
    .o_SUM      (next_addr),
    .o_OVERFLOW (next_ovf)
  );

  logic                    acc_done, pass_end, mismatch;
  logic [p_DATA_WIDTH-1:0] pat_rot;
  logic [7:0]              err_next;

  assign acc_done = o_MEM_REQ & i_MEM_ACK;
  // A carry out means the next step would wrap, so the pass stops at the top of memory.
  assign pass_end = next_ovf | (next_addr > last_q);
  assign pat_rot  = {pat[p_DATA_WIDTH-2:0], pat[p_DATA_WIDTH-1]};
  assign mismatch = (state == READ) & acc_done & (i_MEM_RDATA != pat);
  assign err_next = (mismatch && o_ERR_COUNT != c_ERR_MAX) ? o_ERR_COUNT + 8'd1 : o_ERR_COUNT;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state       <= IDLE;
      base_q      <= '0;
      last_q      <= '0;
      pat         <= '0;
      o_BUSY      <= 1'b0;
      o_DONE      <= 1'b0;
      o_PASS      <= 1'b0;
      o_ERR_COUNT <= '0;
      o_FAIL_ADDR <= '0;
      o_MEM_REQ   <= 1'b0;
      o_MEM_WE    <= 1'b0;
      o_MEM_ADDR  <= '0;
      o_MEM_WDATA <= '0;
    end else begin
      o_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (i_START) begin
            base_q      <= i_BASE_ADDR;
            last_q      <= i_LAST_ADDR;
            o_ERR_COUNT <= '0;
            o_FAIL_ADDR <= '0;
            o_PASS      <= 1'b0;
            if (i_LAST_ADDR < i_BASE_ADDR) begin
              state <= FINISH;
            end else begin
              state       <= WRITE;
              o_BUSY      <= 1'b1;
              o_MEM_REQ   <= 1'b1;
              o_MEM_WE    <= 1'b1;
              o_MEM_ADDR  <= i_BASE_ADDR;
              o_MEM_WDATA <= c_PAT0;
              pat         <= c_PAT0;
            end
          end
        end
        WRITE: begin
          if (acc_done) begin
            if (pass_end) begin
              // Read pass starts back-to-back with the last write.
              state       <= READ;
              o_MEM_WE    <= 1'b0;
              o_MEM_ADDR  <= base_q;
              o_MEM_WDATA <= '0;
              pat         <= c_PAT0;
            end else begin
              o_MEM_ADDR  <= next_addr;
              o_MEM_WDATA <= pat_rot;
              pat         <= pat_rot;
            end
          end
        end
        READ: begin
          if (acc_done) begin
            o_ERR_COUNT <= err_next;
            if (mismatch && o_ERR_COUNT == '0) o_FAIL_ADDR <= o_MEM_ADDR;
            if (pass_end) begin
              state      <= FINISH;
              o_BUSY     <= 1'b0;
              o_MEM_REQ  <= 1'b0;
              o_MEM_ADDR <= '0;
              o_DONE     <= 1'b1;
              o_PASS     <= (err_next == '0);
            end else begin
              o_MEM_ADDR <= next_addr;
              pat        <= pat_rot;
            end
          end
        end
        FINISH: begin
          // An empty window arrives here without DONE, so it spends one extra cycle raising it.
          if (o_DONE) state <= IDLE;
          else        o_DONE <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_walk_ctrl.sv
// Self-checking bench for mem_walk_ctrl: directed cases plus randomized windows,
// ack timing and read faults, checked against a list-based reference model.
module tb_mem_walk_ctrl;
  typedef struct packed {logic we; logic [7:0] addr; logic [7:0] data;} acc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // DUT A: 8-bit address, stride 1
  logic       a_start, a_busy, a_done, a_pass, a_req, a_we, a_ack;
  logic [7:0] a_base, a_last, a_err, a_fail, a_addr, a_wdata, a_rdata;
  // DUT B: 8-bit address, stride 2
  logic       b_start, b_busy, b_done, b_pass, b_req, b_we, b_ack;
  logic [7:0] b_base, b_last, b_err, b_fail, b_addr, b_wdata, b_rdata;
  // DUT C: 9-bit address, stride 1
  logic       c_start, c_busy, c_done, c_pass, c_req, c_we, c_ack;
  logic [8:0] c_base, c_last, c_fail, c_addr;
  logic [7:0] c_err, c_wdata, c_rdata;

  mem_walk_ctrl #(.p_ADDR_WIDTH(8), .p_DATA_WIDTH(8), .p_STRIDE(1)) u_dut_a (
    .i_CLK(clk), .i_RST(rst), .i_START(a_start), .i_BASE_ADDR(a_base), .i_LAST_ADDR(a_last),
    .o_BUSY(a_busy), .o_DONE(a_done), .o_PASS(a_pass), .o_ERR_COUNT(a_err), .o_FAIL_ADDR(a_fail),
    .o_MEM_REQ(a_req), .o_MEM_WE(a_we), .o_MEM_ADDR(a_addr), .o_MEM_WDATA(a_wdata),
    .i_MEM_ACK(a_ack), .i_MEM_RDATA(a_rdata));

  mem_walk_ctrl #(.p_ADDR_WIDTH(8), .p_DATA_WIDTH(8), .p_STRIDE(2)) u_dut_b (
    .i_CLK(clk), .i_RST(rst), .i_START(b_start), .i_BASE_ADDR(b_base), .i_LAST_ADDR(b_last),
    .o_BUSY(b_busy), .o_DONE(b_done), .o_PASS(b_pass), .o_ERR_COUNT(b_err), .o_FAIL_ADDR(b_fail),
    .o_MEM_REQ(b_req), .o_MEM_WE(b_we), .o_MEM_ADDR(b_addr), .o_MEM_WDATA(b_wdata),
    .i_MEM_ACK(b_ack), .i_MEM_RDATA(b_rdata));

  mem_walk_ctrl #(.p_ADDR_WIDTH(9), .p_DATA_WIDTH(8), .p_STRIDE(1)) u_dut_c (
    .i_CLK(clk), .i_RST(rst), .i_START(c_start), .i_BASE_ADDR(c_base), .i_LAST_ADDR(c_last),
    .o_BUSY(c_busy), .o_DONE(c_done), .o_PASS(c_pass), .o_ERR_COUNT(c_err), .o_FAIL_ADDR(c_fail),
    .o_MEM_REQ(c_req), .o_MEM_WE(c_we), .o_MEM_ADDR(c_addr), .o_MEM_WDATA(c_wdata),
    .i_MEM_ACK(c_ack), .i_MEM_RDATA(c_rdata));

  // Memory models and access logs
  logic [7:0] a_mem [256];
  logic [7:0] b_mem [256];
  acc_t       a_log[$];
  acc_t       b_log[$];
  int         c_cnt = 0;
  logic       f_en;
  logic [7:0] f_addr, f_val;

  always_comb begin
    a_rdata = a_mem[a_addr];
    if (f_en && a_addr == f_addr) a_rdata = f_val;
  end
  always_comb b_rdata = b_mem[b_addr];

  always @(posedge clk) begin
    if (!rst && a_req && a_ack) begin
      if (a_we) a_mem[a_addr] <= a_wdata;
      a_log.push_back({a_we, a_addr, a_we ? a_wdata : 8'h00});
    end
    if (!rst && b_req && b_ack) begin
      if (b_we) b_mem[b_addr] <= b_wdata;
      b_log.push_back({b_we, b_addr, b_we ? b_wdata : 8'h00});
    end
    if (!rst && c_req && c_ack) c_cnt <= c_cnt + 1;
  end

  // Ack driver for DUT A: 0 = tied high, 1 = random, 2 = withhold 3 cycles on write to addr 1
  int a_ack_mode = 0;
  int hold = 0;
  int stable_bad = 0;
  initial begin
    forever begin
      @(negedge clk);
      case (a_ack_mode)
        1: begin a_ack = 1'($urandom_range(0, 1)); hold = 0; end
        2: begin
          if (a_req && a_we && a_addr == 8'd1 && hold < 3) begin
            a_ack = 1'b0;
            hold++;
            if (a_wdata != 8'h02) stable_bad++;
          end else a_ack = 1'b1;
        end
        default: begin a_ack = 1'b1; hold = 0; end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the list of accesses and verdict for a stride-1 window on DUT A
  acc_t       exp_q[$];
  int         m_n;
  logic [7:0] m_err, m_fail;
  logic       m_pass;

  task automatic build_model(input logic [7:0] base, input logic [7:0] last);
    logic [7:0] p, rd;
    exp_q.delete();
    m_n = 0; m_err = 0; m_fail = 0;
    if (last >= base)
      for (int a = int'(base); a <= int'(last); a++) begin
        exp_q.push_back({1'b1, 8'(a), 8'(1 << (m_n % 8))});
        m_n++;
      end
    for (int i = 0; i < m_n; i++) begin
      p  = 8'(1 << (i % 8));
      rd = (f_en && 8'(int'(base) + i) == f_addr) ? f_val : p;
      exp_q.push_back({1'b0, 8'(int'(base) + i), 8'h00});
      if (rd != p) begin
        if (m_err == 0) m_fail = 8'(int'(base) + i);
        if (m_err != 8'd255) m_err++;
      end
    end
    m_pass = (m_n > 0) && (m_err == 0);
  endtask

  task automatic run_a(input logic [7:0] base, input logic [7:0] last, input int exp_lat,
                       input string tag);
    int k, nbad;
    build_model(base, last);
    @(negedge clk);
    a_log.delete();
    a_start = 1'b1; a_base = base; a_last = last;
    @(negedge clk);
    a_start = 1'b0;
    k = 1;
    chk({tag, "_req_lat"}, 64'(a_req), 64'(m_n > 0));
    while (!a_done && k < 3000) begin @(negedge clk); k++; end
    chk({tag, "_done"}, 64'(a_done), 64'(1));
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
    chk({tag, "_pass"}, 64'(a_pass), 64'(m_pass));
    chk({tag, "_err"}, 64'(a_err), 64'(m_err));
    chk({tag, "_fail_addr"}, 64'(a_fail), 64'(m_fail));
    chk({tag, "_busy"}, 64'(a_busy), 64'(0));
    chk({tag, "_acc_count"}, 64'(a_log.size()), 64'(exp_q.size()));
    nbad = 0;
    for (int i = 0; i < a_log.size() && i < exp_q.size(); i++)
      if (a_log[i] !== exp_q[i]) nbad++;
    chk({tag, "_acc_seq"}, 64'(nbad), 64'(0));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(a_done), 64'(0));
  endtask

  initial begin
    int k;
    logic [7:0] rb, rl;
    rst = 1'b1;
    a_start = 0; a_base = 0; a_last = 0;
    b_start = 0; b_base = 0; b_last = 0; b_ack = 1'b1;
    c_start = 0; c_base = 0; c_last = 0; c_ack = 1'b1; c_rdata = 8'h00;
    f_en = 0; f_addr = 0; f_val = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs_a", 64'({a_busy, a_done, a_pass, a_err, a_fail, a_req, a_we, a_addr, a_wdata}), 64'(0));
    rst = 1'b0;

    run_a(8'd0, 8'd3, 9, "t1_basic");
    f_en = 1; f_addr = 8'd2; f_val = 8'h00;
    run_a(8'd0, 8'd3, 9, "t2_fault");
    chk("t2_err_count", 64'(a_err), 64'(1));
    chk("t2_fail_addr", 64'(a_fail), 64'(2));
    f_en = 0;
    run_a(8'd5, 8'd2, 2, "t3_empty");
    a_ack_mode = 2;
    run_a(8'd0, 8'd3, 12, "t4_stall");
    chk("t4_hold_cycles", 64'(hold), 64'(3));
    chk("t4_wdata_stable", 64'(stable_bad), 64'(0));

    a_ack_mode = 1;
    for (int it = 0; it < 6; it++) begin
      rb = 8'($urandom_range(0, 255));
      rl = (it == 5) ? 8'($urandom_range(0, 254)) : rb;
      if (it == 5 && rl >= rb) rb = rl + 8'd1;
      else if (it != 5) rl = 8'(int'(rb) + $urandom_range(0, 30) > 255 ? 255 : int'(rb) + $urandom_range(0, 30));
      f_en = 1'($urandom_range(0, 1));
      f_addr = 8'(int'(rb) + $urandom_range(0, 8));
      f_val = 8'($urandom_range(0, 255));
      run_a(rb, rl, -1, "rand");
    end
    f_en = 0;

    // Reset in the middle of the read pass, then a clean run
    a_ack_mode = 0;
    @(negedge clk);
    a_start = 1'b1; a_base = 8'd0; a_last = 8'd9;
    @(negedge clk);
    a_start = 1'b0;
    k = 0;
    while (!(a_req && !a_we) && k < 50) begin @(negedge clk); k++; end
    chk("rst_reach_read", 64'(a_req && !a_we), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_read_outs", 64'({a_busy, a_done, a_pass, a_err, a_fail, a_req, a_we, a_addr, a_wdata}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run_a(8'd0, 8'd3, 9, "post_rst");

    // Stride 2 near the top of memory: overflow ends each pass
    @(negedge clk);
    b_log.delete();
    b_start = 1'b1; b_base = 8'hFC; b_last = 8'hFF;
    @(negedge clk);
    b_start = 1'b0;
    k = 1;
    while (!b_done && k < 100) begin @(negedge clk); k++; end
    chk("t5_done", 64'(b_done), 64'(1));
    chk("t5_pass", 64'(b_pass), 64'(1));
    chk("t5_acc_count", 64'(b_log.size()), 64'(4));
    if (b_log.size() == 4) begin
      chk("t5_acc0", 64'(b_log[0]), 64'({1'b1, 8'hFC, 8'h01}));
      chk("t5_acc1", 64'(b_log[1]), 64'({1'b1, 8'hFE, 8'h02}));
      chk("t5_acc2", 64'(b_log[2]), 64'({1'b0, 8'hFC, 8'h00}));
      chk("t5_acc3", 64'(b_log[3]), 64'({1'b0, 8'hFE, 8'h00}));
    end

    // 9-bit window 0..299 reading all zeros: error count saturates
    @(negedge clk);
    k = c_cnt;
    c_start = 1'b1; c_base = 9'd0; c_last = 9'd299;
    @(negedge clk);
    c_start = 1'b0;
    for (int i = 0; i < 1000 && !c_done; i++) @(negedge clk);
    chk("t6_done", 64'(c_done), 64'(1));
    chk("t6_err_sat", 64'(c_err), 64'(255));
    chk("t6_fail_addr", 64'(c_fail), 64'(0));
    chk("t6_pass", 64'(c_pass), 64'(0));
    chk("t6_acc_count", 64'(c_cnt - k), 64'(600));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
